// File: rtl/lvds_tx_pack.sv
// rtl/lvds_tx_pack.sv - buffers 7-bit words and packs pairs into 14-bit serializer frames
// Define LVDS_TX_PACK_UFCNT_EN to add the saturating UF_COUNT underflow counter output.
module lvds_tx_pack #(
  parameter int         DEPTH     = 16,
  parameter logic [6:0] IDLE_WORD = 7'h63
) (
  input  logic                   WCLK,
  input  logic                   RESET,
  input  logic [6:0]             DATA_IN,
  input  logic                   align_serializer_i,
  input  logic                   DATA_VALID,
  output logic                   DATA_READY,
  input  logic                   FLUSH,
  input  logic                   enable,
  output logic [13:0]            TDATA,
  output logic                   align_serializer_o,
  output logic                   UNDERFLOW,
  output logic [$clog2(DEPTH):0] FILL
`ifdef LVDS_TX_PACK_UFCNT_EN
  ,
  output logic [15:0]            UF_COUNT
`endif
);
  localparam int          PW        = $clog2(DEPTH);
  localparam logic [PW:0] FULL      = (PW+1)'(DEPTH);
  localparam logic [PW:0] TWO       = (PW+1)'(2);
  localparam logic [13:0] IDLE_PAIR = {IDLE_WORD, IDLE_WORD};

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_p1;
  logic [PW:0]   fill_q, fill_d;
  logic [13:0]   tdata_q, tdata_d;
  logic          align_q, align_d;
  logic          uf_q, uf_d;
  logic          push, pop, starve;

  // Pop eligibility uses registered occupancy, so a word pushed on the strobe cycle waits.
  assign rd_p1      = rd_q + PW'(1);
  assign DATA_READY = RESET && !FLUSH && (fill_q < FULL);
  assign push       = DATA_VALID && DATA_READY;
  assign pop        = enable && !FLUSH && (fill_q >= TWO);
  assign starve     = enable && !FLUSH && (fill_q < TWO);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    tdata_d = tdata_q;
    align_d = align_q;
    uf_d    = starve;
    if (FLUSH) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
      if (enable) begin
        tdata_d = IDLE_PAIR;
        align_d = 1'b0;
      end
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop) begin
        tdata_d = {mem_q[rd_q][6:0], mem_q[rd_p1][6:0]};
        align_d = mem_q[rd_q][7];
        rd_d    = rd_q + PW'(2);
      end else if (starve) begin
        // A lone buffered word is held back rather than sent half-paired.
        tdata_d = IDLE_PAIR;
        align_d = 1'b0;
      end
      fill_d = fill_q + (PW+1)'(push) - (pop ? TWO : '0);
    end
  end

  always_ff @(posedge WCLK) begin
    if (push) mem_q[wr_q] <= {align_serializer_i, DATA_IN};
  end

  always_ff @(posedge WCLK or negedge RESET) begin
    if (!RESET) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      tdata_q <= IDLE_PAIR;
      align_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      tdata_q <= tdata_d;
      align_q <= align_d;
      uf_q    <= uf_d;
    end
  end

  assign TDATA              = tdata_q;
  assign align_serializer_o = align_q;
  assign UNDERFLOW          = uf_q;
  assign FILL               = fill_q;

`ifdef LVDS_TX_PACK_UFCNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (FLUSH) uf_cnt_d = '0;
    else if (starve && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  always_ff @(posedge WCLK or negedge RESET) begin
    if (!RESET) uf_cnt_q <= '0;
    else        uf_cnt_q <= uf_cnt_d;
  end

  assign UF_COUNT = uf_cnt_q;
`endif

endmodule

// File: tb/tb_lvds_tx_pack.sv
// tb/tb_lvds_tx_pack.sv - scoreboard bench for lvds_tx_pack (directed vectors)
module tb_lvds_tx_pack;
  localparam logic [13:0] IDLE2 = 14'h31E3;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  data_in = '0;
  logic        align_i = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        flush = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] tdata;
  logic        align_o;
  logic        uf;
  logic [4:0]  fill;
`ifdef LVDS_TX_PACK_UFCNT_EN
  logic [15:0] uf_count;
`endif

  lvds_tx_pack #(.DEPTH(16), .IDLE_WORD(7'h63)) dut (
    .WCLK(wclk), .RESET(rst_n), .DATA_IN(data_in), .align_serializer_i(align_i),
    .DATA_VALID(valid), .DATA_READY(ready), .FLUSH(flush), .enable(enable),
    .TDATA(tdata), .align_serializer_o(align_o), .UNDERFLOW(uf), .FILL(fill)
`ifdef LVDS_TX_PACK_UFCNT_EN
    , .UF_COUNT(uf_count)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [13:0] tdata;
    logic        align;
    logic        uf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted strobe yields one frame update on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      if (rst_n && enable) begin
        @(negedge wclk);
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_frame", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("frame_tdata", tdata, e.tdata);
          chk("frame_align", align_o, e.align);
          chk("frame_underflow", uf, e.uf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic push(input logic [6:0] d, input logic a);
    data_in = d;
    align_i = a;
    valid   = 1'b1;
    @(negedge wclk);
    valid   = 1'b0;
  endtask

  task automatic strobe(input logic [13:0] t, input logic a, input logic u);
    exp_t e;
    e.tdata = t;
    e.align = a;
    e.uf    = u;
    sb_q.push_back(e);
    enable = 1'b1;
    @(negedge wclk);
    enable = 1'b0;
  endtask

  initial begin
    logic [6:0] w0, w1;
    cyc(2);
    chk("rst_tdata", tdata, IDLE2);
    chk("rst_align", align_o, 1'b0);
    chk("rst_underflow", uf, 1'b0);
    chk("rst_fill", fill, 0);
    chk("rst_ready", ready, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    chk("ready_after_reset", ready, 1'b1);

    for (int i = 0; i < 3; i++) begin
      strobe(IDLE2, 1'b0, 1'b1);
      cyc(1);
      chk("underflow_one_cycle", uf, 1'b0);
      cyc(5);
    end
    chk("idle_fill", fill, 0);
`ifdef LVDS_TX_PACK_UFCNT_EN
    chk("uf_count_3", uf_count, 3);
`endif

    push(7'h11, 1'b1);
    push(7'h22, 1'b0);
    chk("pair_fill2", fill, 2);
    strobe(14'h08A2, 1'b1, 1'b0);
    chk("pair_fill0", fill, 0);

    push(7'h55, 1'b0);
    strobe(IDLE2, 1'b0, 1'b1);
    chk("single_held_fill", fill, 1);
    push(7'h2A, 1'b0);
    strobe(14'h2AAA, 1'b0, 1'b0);
    chk("single_paired_fill", fill, 0);

    for (int i = 0; i < 16; i++) push(7'(i), (i % 4) == 0);
    chk("full_fill", fill, 16);
    chk("full_ready", ready, 1'b0);
    data_in = 7'h7F;
    valid   = 1'b1;
    cyc(1);
    valid   = 1'b0;
    chk("full_reject_fill", fill, 16);
    for (int k = 0; k < 8; k++) begin
      w0 = 7'(2 * k);
      w1 = 7'(2 * k + 1);
      strobe({w0, w1}, (k % 2) == 0, 1'b0);
      if (k >= 4) cyc(6);
    end
    chk("drain_fill", fill, 0);

    push(7'h40, 1'b0);
    data_in = 7'h41;
    valid   = 1'b1;
    strobe(IDLE2, 1'b0, 1'b1);
    valid   = 1'b0;
    chk("push_on_strobe_fill", fill, 2);
    for (int i = 2; i < 9; i++) push(7'h40 + 7'(i), 1'b0);
    chk("pre_flush_fill", fill, 9);
    flush   = 1'b1;
    data_in = 7'h7F;
    valid   = 1'b1;
    #1;
    chk("flush_ready", ready, 1'b0);
    strobe(IDLE2, 1'b0, 1'b0);
    flush   = 1'b0;
    valid   = 1'b0;
    chk("flush_fill", fill, 0);
`ifdef LVDS_TX_PACK_UFCNT_EN
    chk("uf_count_flush", uf_count, 0);
`endif
    strobe(IDLE2, 1'b0, 1'b1);
`ifdef LVDS_TX_PACK_UFCNT_EN
    chk("uf_count_after_flush", uf_count, 1);
`endif
    push(7'h01, 1'b1);
    push(7'h02, 1'b0);
    strobe(14'h0082, 1'b1, 1'b0);

    push(7'h03, 1'b0);
    push(7'h04, 1'b0);
    push(7'h05, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tdata", tdata, IDLE2);
    chk("async_rst_align", align_o, 1'b0);
    chk("async_rst_underflow", uf, 1'b0);
    chk("async_rst_fill", fill, 0);
    chk("async_rst_ready", ready, 1'b0);
`ifdef LVDS_TX_PACK_UFCNT_EN
    chk("async_rst_uf_count", uf_count, 0);
`endif
    @(negedge wclk);
    rst_n = 1'b1;
    cyc(1);
    strobe(IDLE2, 1'b0, 1'b1);
    chk("post_rst_fill", fill, 0);
    cyc(3);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
